// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin share of one MMU memory port between two level-request masters.
// Latency : req seen in IDLE -> s_req_o next cycle; MMU rvalid -> master rvalid next cycle.
// Backpr. : one transaction outstanding; a master holds req until its rvalid, others wait in IDLE.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   m0_* / m1_*           master request (req/addr/we/be/wdata) and response (rvalid/err/rdata)
//   s_*                   MMU side: one-cycle s_req_o pulse plus held request fields, response in
//   busy_o, grant_o       not-IDLE indicator, id of current or last granted master
//   timeout_o, stray_o    forced-error pulse, sticky "unexpected MMU rvalid" flag
module mem_port_arbiter #(
   parameter int MEM_W          = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 m0_req_i,
   input  logic [31:0]          m0_addr_i,
   input  logic                 m0_we_i,
   input  logic [MEM_W/8-1:0]   m0_be_i,
   input  logic [MEM_W-1:0]     m0_wdata_i,
   output logic                 m0_rvalid_o,
   output logic                 m0_err_o,
   output logic [MEM_W-1:0]     m0_rdata_o,

   input  logic                 m1_req_i,
   input  logic [31:0]          m1_addr_i,
   input  logic                 m1_we_i,
   input  logic [MEM_W/8-1:0]   m1_be_i,
   input  logic [MEM_W-1:0]     m1_wdata_i,
   output logic                 m1_rvalid_o,
   output logic                 m1_err_o,
   output logic [MEM_W-1:0]     m1_rdata_o,

   output logic                 s_req_o,
   output logic [31:0]          s_addr_o,
   output logic                 s_we_o,
   output logic [MEM_W/8-1:0]   s_be_o,
   output logic [MEM_W-1:0]     s_wdata_o,
   input  logic                 s_rvalid_i,
   input  logic                 s_err_i,
   input  logic [MEM_W-1:0]     s_rdata_i,

   output logic                 busy_o,
   output logic                 grant_o,
   output logic                 timeout_o,
   output logic                 stray_o
);

   // A disabled timeout still needs a legal 1-bit counter.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state;
   logic              last_grant;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic              pick;
   logic              resp_vld;
   logic              resp_err;
   logic              to_fire;
   logic [MEM_W-1:0]  resp_dat;

   // On a tie the master that was not served last wins.
   assign pick    = (m0_req_i && m1_req_i) ? ~last_grant : m1_req_i;
   assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
   assign busy_o  = (state != S_IDLE);

   // Response source while a transaction is open. A real MMU response beats a
   // timeout that would fire in the same cycle. The ISSUE cycle already counts
   // as cycle 1, so only a timeout of 1 can fire there.
   always_comb begin
      resp_vld = 1'b0;
      resp_err = 1'b0;
      resp_dat = '0;
      to_fire  = 1'b0;
      if (state == S_ISSUE || state == S_WAIT) begin
         if (s_rvalid_i) begin
            resp_vld = 1'b1;
            resp_err = s_err_i;
            resp_dat = s_rdata_i;
         end else if (TO_EN && ((state == S_ISSUE) ? (TO_VAL == CNT_ONE)
                                                    : (cnt_inc == TO_VAL))) begin
            resp_vld = 1'b1;
            resp_err = 1'b1;
            to_fire  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         last_grant  <= 1'b1;
         grant_o     <= 1'b0;
         cnt         <= '0;
         s_req_o     <= 1'b0;
         s_addr_o    <= '0;
         s_we_o      <= 1'b0;
         s_be_o      <= '0;
         s_wdata_o   <= '0;
         m0_rvalid_o <= 1'b0;
         m0_err_o    <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rvalid_o <= 1'b0;
         m1_err_o    <= 1'b0;
         m1_rdata_o  <= '0;
         timeout_o   <= 1'b0;
         stray_o     <= 1'b0;
      end else begin
         // Strobes live for one cycle only.
         s_req_o     <= 1'b0;
         timeout_o   <= 1'b0;
         m0_rvalid_o <= 1'b0;
         m0_err_o    <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rvalid_o <= 1'b0;
         m1_err_o    <= 1'b0;
         m1_rdata_o  <= '0;

         case (state)
            S_IDLE: begin
               if (s_rvalid_i) stray_o <= 1'b1;
               if (m0_req_i || m1_req_i) begin
                  grant_o    <= pick;
                  last_grant <= pick;
                  s_addr_o   <= pick ? m1_addr_i  : m0_addr_i;
                  s_we_o     <= pick ? m1_we_i    : m0_we_i;
                  s_be_o     <= pick ? m1_be_i    : m0_be_i;
                  s_wdata_o  <= pick ? m1_wdata_i : m0_wdata_i;
                  s_req_o    <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               cnt <= (state == S_ISSUE) ? CNT_ONE : cnt_inc;
               if (resp_vld) begin
                  timeout_o <= to_fire;
                  if (grant_o) begin
                     m1_rvalid_o <= 1'b1;
                     m1_err_o    <= resp_err;
                     m1_rdata_o  <= resp_dat;
                  end else begin
                     m0_rvalid_o <= 1'b1;
                     m0_err_o    <= resp_err;
                     m0_rdata_o  <= resp_dat;
                  end
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_DONE: begin
               // The served master still holds req here, so reqs are ignored.
               if (s_rvalid_i) stray_o <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_i, m1_req_i;
   logic [31:0] m0_addr_i, m1_addr_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic [31:0] m0_wdata_i, m1_wdata_i;
   logic        m0_rvalid_o, m1_rvalid_o;
   logic        m0_err_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_req_o;
   logic [31:0] s_addr_o;
   logic        s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_wdata_o;
   logic        s_rvalid_i, s_err_i;
   logic [31:0] s_rdata_i;
   logic        busy_o, grant_o, timeout_o, stray_o;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   mem_port_arbiter #(.MEM_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
      .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
      .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
      .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
      .s_rvalid_i(s_rvalid_i), .s_err_i(s_err_i), .s_rdata_i(s_rdata_i),
      .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o), .stray_o(stray_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Starts at a negedge in IDLE with requests already driven; ends at the
   // negedge of the following IDLE cycle. lat = cycles from s_req_o to MMU rvalid.
   task automatic txn(input logic g, input logic [31:0] addr, input int lat,
                      input logic [31:0] rd, input logic er);
      step();
      chk1 ("issue_req",   s_req_o, 1'b1);
      chk1 ("issue_grant", grant_o, g);
      chk32("issue_addr",  s_addr_o, addr);
      chk1 ("issue_we",    s_we_o, g ? m1_we_i : m0_we_i);
      chk32("issue_be",    32'(s_be_o), 32'(g ? m1_be_i : m0_be_i));
      chk32("issue_wdata", s_wdata_o, g ? m1_wdata_i : m0_wdata_i);
      if (lat == 0) begin
         s_rvalid_i = 1'b1; s_err_i = er; s_rdata_i = rd;
      end
      for (int j = 1; j <= lat; j++) begin
         step();
         chk1("req_single",   s_req_o, 1'b0);
         chk1("no_early_rsp", g ? m1_rvalid_o : m0_rvalid_o, 1'b0);
         if (j == lat) begin
            s_rvalid_i = 1'b1; s_err_i = er; s_rdata_i = rd;
         end
      end
      step();
      s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = 32'h0;
      chk1 ("rsp_vld",    g ? m1_rvalid_o : m0_rvalid_o, 1'b1);
      chk1 ("rsp_err",    g ? m1_err_o    : m0_err_o,    er);
      chk32("rsp_data",   g ? m1_rdata_o  : m0_rdata_o,  rd);
      chk1 ("other_vld",  g ? m0_rvalid_o : m1_rvalid_o, 1'b0);
      chk32("other_data", g ? m0_rdata_o  : m1_rdata_o,  32'h0);
      chk1 ("done_req",   s_req_o, 1'b0);
      chk1 ("done_busy",  busy_o, 1'b1);
      step();
      chk1("idle_vld",  g ? m1_rvalid_o : m0_rvalid_o, 1'b0);
      chk1("idle_busy", busy_o, 1'b0);
      chk1("idle_req",  s_req_o, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      m0_req_i = 1'b0; m0_addr_i = '0; m0_we_i = 1'b0; m0_be_i = '0; m0_wdata_i = '0;
      m1_req_i = 1'b0; m1_addr_i = '0; m1_we_i = 1'b0; m1_be_i = '0; m1_wdata_i = '0;
      s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
      step(); step();

      // Reset state
      chk1 ("rst_sreq",    s_req_o, 1'b0);
      chk1 ("rst_busy",    busy_o, 1'b0);
      chk1 ("rst_grant",   grant_o, 1'b0);
      chk1 ("rst_stray",   stray_o, 1'b0);
      chk1 ("rst_timeout", timeout_o, 1'b0);
      chk1 ("rst_m0vld",   m0_rvalid_o, 1'b0);
      chk1 ("rst_m1vld",   m1_rvalid_o, 1'b0);
      chk32("rst_saddr",   s_addr_o, 32'h0);
      rst = 1'b0;
      step();

      // Single read, MMU answers 2 cycles after s_req_o
      m0_req_i = 1'b1; m0_addr_i = 32'h2000; m0_be_i = 4'hF;
      txn(1'b0, 32'h2000, 2, 32'hDEADBEEF, 1'b0);
      m0_req_i = 1'b0;

      // Contention straight out of reset: 0,1,0,1
      rst = 1'b1;
      step();
      rst = 1'b0;
      m0_addr_i = 32'h0100; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h0;
      m1_addr_i = 32'h0200; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'hA5A50001;
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      txn(1'b0, 32'h0100, 1, 32'h00000011, 1'b0);
      txn(1'b1, 32'h0200, 1, 32'h00000022, 1'b0);
      txn(1'b0, 32'h0100, 1, 32'h00000033, 1'b0);
      txn(1'b1, 32'h0200, 1, 32'h00000044, 1'b1);

      // Held req: m1 holds through DONE, drops in the following IDLE cycle
      m0_req_i = 1'b0; m1_addr_i = 32'h0240;
      txn(1'b1, 32'h0240, 1, 32'h00000055, 1'b0);
      m1_req_i = 1'b0;
      step();
      chk1("held_noreissue_req",  s_req_o, 1'b0);
      chk1("held_noreissue_busy", busy_o, 1'b0);

      // Zero-latency MMU with err, back-to-back every 3 cycles
      m0_req_i = 1'b1; m0_addr_i = 32'h0400;
      txn(1'b0, 32'h0400, 0, 32'hCAFE0001, 1'b1);
      txn(1'b0, 32'h0400, 0, 32'hCAFE0002, 1'b1);
      m0_req_i = 1'b0;
      step();
      chk1("no_stray_yet", stray_o, 1'b0);

      // Timeout after 8 cycles in ISSUE+WAIT
      m0_req_i = 1'b1; m0_addr_i = 32'h0500; s_rdata_i = 32'h12345678;
      step();
      chk1("to_issue", s_req_o, 1'b1);
      for (int k = 2; k <= 8; k++) begin
         step();
         chk1("to_wait_vld",   m0_rvalid_o, 1'b0);
         chk1("to_wait_pulse", timeout_o, 1'b0);
      end
      step();
      chk1 ("to_vld",    m0_rvalid_o, 1'b1);
      chk1 ("to_err",    m0_err_o, 1'b1);
      chk32("to_rdata",  m0_rdata_o, 32'h0);
      chk1 ("to_pulse",  timeout_o, 1'b1);
      chk1 ("to_m1vld",  m1_rvalid_o, 1'b0);
      m0_req_i = 1'b0;
      step();
      chk1("to_pulse_end", timeout_o, 1'b0);
      chk1("to_idle",      busy_o, 1'b0);
      s_rvalid_i = 1'b1; s_rdata_i = 32'h00000055;
      step();
      s_rvalid_i = 1'b0; s_rdata_i = 32'h0;
      chk1("late_stray",  stray_o, 1'b1);
      chk1("late_m0vld",  m0_rvalid_o, 1'b0);
      chk1("late_m1vld",  m1_rvalid_o, 1'b0);
      chk1("late_busy",   busy_o, 1'b0);

      // Reset mid-WAIT (last grant was m0, so a tie would go to m1 without reset)
      m0_req_i = 1'b1; m0_addr_i = 32'h3000;
      step();
      chk1("mr_issue", s_req_o, 1'b1);
      step(); step(); step();
      chk1("mr_busy_before", busy_o, 1'b1);
      rst = 1'b1;
      #1;
      chk1 ("mr_busy",  busy_o, 1'b0);
      chk1 ("mr_sreq",  s_req_o, 1'b0);
      chk1 ("mr_grant", grant_o, 1'b0);
      chk1 ("mr_stray", stray_o, 1'b0);
      chk1 ("mr_m0vld", m0_rvalid_o, 1'b0);
      chk32("mr_saddr", s_addr_o, 32'h0);
      step();
      rst = 1'b0; m0_req_i = 1'b0;
      s_rvalid_i = 1'b1; s_rdata_i = 32'h00000077;
      step();
      s_rvalid_i = 1'b0; s_rdata_i = 32'h0;
      chk1("mr_late_stray", stray_o, 1'b1);
      chk1("mr_late_m0vld", m0_rvalid_o, 1'b0);
      chk1("mr_late_busy",  busy_o, 1'b0);
      m0_req_i = 1'b1; m1_req_i = 1'b1; m1_addr_i = 32'h3100;
      txn(1'b0, 32'h3000, 1, 32'h00000088, 1'b0);
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
